// File: rtl/axi_grid_pkg.sv
// rtl/axi_grid_pkg.sv - AXI grid encodings, default request/response bundles and helpers
package axi_grid_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef struct packed {
    logic                        aw_valid;
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        w_valid;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        b_ready;
    logic                        ar_valid;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        r_ready;
  } axi_req_t;

  typedef struct packed {
    logic                      aw_ready;
    logic                      w_ready;
    logic                      b_valid;
    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic                      ar_ready;
    logic                      r_valid;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
  } axi_resp_t;

  // WRAP and the reserved encoding are served as errors.
  function automatic logic burst_legal(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_grid_sni_regfile.sv
// rtl/axi_grid_sni_regfile.sv - word memory with one byte-strobed write port and one combinational read port
module axi_grid_sni_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 256,
  localparam int IDX_W     = $clog2(MEM_DEPTH),
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Reads see the pre-write contents when a write lands on the same edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_grid_sni.sv
// rtl/axi_grid_sni.sv - AXI subordinate network interface serving a local word memory
module axi_grid_sni
  import axi_grid_pkg::*;
#(
  parameter type req_t      = axi_req_t,
  parameter type resp_t     = axi_resp_t,
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 64,
  parameter int  MEM_DEPTH  = 256
) (
  input  logic  clk_i,
  input  logic  arst_ni,
  input  req_t  req_i,
  output resp_t resp_o
);

  localparam int         OFFS     = $clog2(DATA_WIDTH / 8);
  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(OFFS);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFFS) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + (ADDR_WIDTH'(1) << size) : a;
  endfunction

  logic                    active;
  logic [1:0]              w_state;
  logic [AXI_ID_WIDTH-1:0] w_id;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [7:0]              w_len, w_cnt;
  logic [2:0]              w_size;
  logic [1:0]              w_burst;
  logic                    w_err;
  logic                    r_state;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len, r_cnt;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;

  logic w_ok, w_final, w_beat_err, mem_we;
  logic r_ok, r_beat_err, r_last;
  logic [DATA_WIDTH-1:0] rdata;

  assign w_ok       = burst_legal(w_burst) && (w_size <= MAX_SIZE);
  assign w_final    = (w_cnt == w_len);
  assign w_beat_err = !w_ok || !in_range(w_addr) || (req_i.w_last != w_final);
  assign mem_we     = (w_state == W_DATA) && req_i.w_valid && w_ok && in_range(w_addr);

  assign r_ok       = burst_legal(r_burst) && (r_size <= MAX_SIZE);
  assign r_beat_err = !r_ok || !in_range(r_addr);
  assign r_last     = (r_cnt == r_len);

  // Holds the ready outputs low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) active <= 1'b0;
    else          active <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (active && req_i.aw_valid) begin
          w_id    <= req_i.aw_id;
          w_addr  <= req_i.aw_addr;
          w_len   <= req_i.aw_len;
          w_size  <= req_i.aw_size;
          w_burst <= req_i.aw_burst;
          w_cnt   <= '0;
          w_err   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (req_i.w_valid) begin
          w_addr <= next_addr(w_addr, w_size, w_burst);
          w_cnt  <= w_cnt + 8'd1;
          w_err  <= w_err | w_beat_err;
          // An early or missing w_last still closes the burst here.
          if (req_i.w_last || w_final) w_state <= W_RESP;
        end
        W_RESP: if (req_i.b_ready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (r_state == R_IDLE) begin
      if (active && req_i.ar_valid) begin
        r_id    <= req_i.ar_id;
        r_addr  <= req_i.ar_addr;
        r_len   <= req_i.ar_len;
        r_size  <= req_i.ar_size;
        r_burst <= req_i.ar_burst;
        r_cnt   <= '0;
        r_state <= R_DATA;
      end
    end else if (req_i.r_ready) begin
      r_addr <= next_addr(r_addr, r_size, r_burst);
      r_cnt  <= r_cnt + 8'd1;
      if (r_last) r_state <= R_IDLE;
    end
  end

  axi_grid_sni_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_regfile (
    .clk   (clk_i),
    .arst_n(arst_ni),
    .we    (mem_we),
    .waddr (w_addr[OFFS +: IDX_W]),
    .wdata (req_i.w_data),
    .wstrb (req_i.w_strb),
    .raddr (r_addr[OFFS +: IDX_W]),
    .rdata (rdata)
  );

  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = active && (w_state == W_IDLE);
    resp_o.w_ready  = (w_state == W_DATA);
    resp_o.b_valid  = (w_state == W_RESP);
    resp_o.b_id     = w_id;
    resp_o.b_resp   = w_err ? RESP_SLVERR : RESP_OKAY;
    resp_o.ar_ready = active && (r_state == R_IDLE);
    resp_o.r_valid  = (r_state == R_DATA);
    resp_o.r_id     = r_id;
    resp_o.r_data   = ((r_state == R_DATA) && !r_beat_err) ? rdata : '0;
    resp_o.r_resp   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
    resp_o.r_last   = (r_state == R_DATA) && r_last;
  end

endmodule
